// File: rtl/dcache_req_arbiter.sv
// Two-port arbiter onto one dcache addr_ok/data_ok port; one outstanding access, grant/rvalid one cycle after the deciding edge.
// Requests wait (held by requester) until granted; optional perf counters under DCACHE_ARB_PERF_EN.
module dcache_req_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                p0_valid,
  input  logic                p0_we,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic [DATA_W/8-1:0] p0_sel,
  output logic                p0_grant,
  output logic                p0_rvalid,
  output logic [DATA_W-1:0]   p0_rdata,
  input  logic                p1_valid,
  input  logic                p1_we,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  input  logic [DATA_W/8-1:0] p1_sel,
  output logic                p1_grant,
  output logic                p1_rvalid,
  output logic [DATA_W-1:0]   p1_rdata,
  output logic                cache_ce,
  output logic                cache_we,
  output logic [ADDR_W-1:0]   cache_addr,
  output logic [DATA_W-1:0]   cache_data,
  output logic [DATA_W/8-1:0] cache_sel,
  input  logic                cache_addr_ok,
  input  logic                cache_data_ok,
  input  logic [DATA_W-1:0]   cache_rdata,
  output logic                busy
`ifdef DCACHE_ARB_PERF_EN
  ,
  output logic [31:0]         perf_p0_grants,
  output logic [31:0]         perf_p1_grants,
  output logic [31:0]         perf_wait_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DRAIN} state_t;

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  state_t                r_state;
  state_t                w_next_state;
  logic [3:0]            r_starve;
  logic [3:0]            w_starve_next;
  logic                  r_owner;
  logic                  r_we;
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [DATA_W/8-1:0]   r_sel;
  logic                  r_ce;
  logic                  r_busy;
  logic                  r_p0_grant;
  logic                  r_p1_grant;
  logic                  r_p0_rvalid;
  logic                  r_p1_rvalid;
  logic [DATA_W-1:0]     r_p0_rdata;
  logic [DATA_W-1:0]     r_p1_rdata;

  logic w_p0_req;
  logic w_p1_win;
  logic w_p0_win;
  logic w_flush_kill;
  logic w_grant0;
  logic w_grant1;
  logic w_complete;

  assign w_p0_req     = p0_valid & ~flush;
  assign w_p1_win     = p1_valid & ((r_starve == LIM) | ~w_p0_req);
  assign w_p0_win     = w_p0_req & ~w_p1_win;
  // Flush only ever cancels work owned by port 0.
  assign w_flush_kill = flush & ~r_owner;

  always_comb begin
    w_next_state  = r_state;
    w_grant0      = 1'b0;
    w_grant1      = 1'b0;
    w_complete    = 1'b0;
    w_starve_next = r_starve;
    case (r_state)
      S_IDLE: begin
        if (w_p1_win) begin
          w_grant1     = 1'b1;
          w_next_state = S_ADDR;
        end else if (w_p0_win) begin
          w_grant0     = 1'b1;
          w_next_state = S_ADDR;
        end
        if (w_grant1 || !p1_valid) begin
          w_starve_next = 4'd0;
        end else if (w_grant0 && (r_starve < LIM)) begin
          w_starve_next = r_starve + 4'd1;
        end
      end
      S_ADDR: begin
        if (w_flush_kill) begin
          if (!cache_addr_ok || cache_data_ok) w_next_state = S_IDLE;
          else                                 w_next_state = S_DRAIN;
        end else if (cache_addr_ok) begin
          if (cache_data_ok) begin
            w_complete   = 1'b1;
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (cache_data_ok) begin
          w_complete   = ~w_flush_kill;
          w_next_state = S_IDLE;
        end else if (w_flush_kill) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cache_data_ok) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_starve    <= 4'd0;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_sel       <= '0;
      r_ce        <= 1'b0;
      r_busy      <= 1'b0;
      r_p0_grant  <= 1'b0;
      r_p1_grant  <= 1'b0;
      r_p0_rvalid <= 1'b0;
      r_p1_rvalid <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_starve    <= w_starve_next;
      r_ce        <= (w_next_state == S_ADDR);
      r_busy      <= (w_next_state != S_IDLE);
      r_p0_grant  <= w_grant0;
      r_p1_grant  <= w_grant1;
      r_p0_rvalid <= w_complete & ~r_owner;
      r_p1_rvalid <= w_complete & r_owner;
      if (w_grant0 || w_grant1) begin
        r_owner <= w_grant1;
        r_we    <= w_grant1 ? p1_we    : p0_we;
        r_addr  <= w_grant1 ? p1_addr  : p0_addr;
        r_wdata <= w_grant1 ? p1_wdata : p0_wdata;
        r_sel   <= w_grant1 ? p1_sel   : p0_sel;
      end
      // Stores return zero so a stale load value never leaks to the requester.
      if (w_complete && !r_owner) r_p0_rdata <= r_we ? '0 : cache_rdata;
      if (w_complete &&  r_owner) r_p1_rdata <= r_we ? '0 : cache_rdata;
    end
  end

  assign p0_grant   = r_p0_grant;
  assign p1_grant   = r_p1_grant;
  assign p0_rvalid  = r_p0_rvalid;
  assign p1_rvalid  = r_p1_rvalid;
  assign p0_rdata   = r_p0_rdata;
  assign p1_rdata   = r_p1_rdata;
  assign cache_ce   = r_ce;
  assign cache_we   = r_we;
  assign cache_addr = r_addr;
  assign cache_data = r_wdata;
  assign cache_sel  = r_sel;
  assign busy       = r_busy;

`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] r_perf_p0;
  logic [31:0] r_perf_p1;
  logic [31:0] r_perf_wait;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_p0   <= 32'd0;
      r_perf_p1   <= 32'd0;
      r_perf_wait <= 32'd0;
    end else begin
      if (w_grant0) r_perf_p0 <= r_perf_p0 + 32'd1;
      if (w_grant1) r_perf_p1 <= r_perf_p1 + 32'd1;
      if (r_state == S_ADDR || r_state == S_DATA) r_perf_wait <= r_perf_wait + 32'd1;
    end
  end

  assign perf_p0_grants   = r_perf_p0;
  assign perf_p1_grants   = r_perf_p1;
  assign perf_wait_cycles = r_perf_wait;
`endif

endmodule

// File: tb/tb_dcache_req_arbiter.sv
// Self-checking bench for dcache_req_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of arbitration, starvation and completion routing.
module tb_dcache_req_arbiter;
  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        p0_valid, p0_we, p0_grant, p0_rvalid;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [3:0]  p0_sel;
  logic        p1_valid, p1_we, p1_grant, p1_rvalid;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [3:0]  p1_sel;
  logic        cache_ce, cache_we, cache_addr_ok, cache_data_ok, busy;
  logic [31:0] cache_addr, cache_data, cache_rdata;
  logic [3:0]  cache_sel;
`ifdef DCACHE_ARB_PERF_EN
  logic [31:0] perf_p0_grants, perf_p1_grants, perf_wait_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dcache_req_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .p0_valid(p0_valid), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_sel(p0_sel),
    .p0_grant(p0_grant), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_valid(p1_valid), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_sel(p1_sel),
    .p1_grant(p1_grant), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .cache_ce(cache_ce), .cache_we(cache_we), .cache_addr(cache_addr), .cache_data(cache_data),
    .cache_sel(cache_sel), .cache_addr_ok(cache_addr_ok), .cache_data_ok(cache_data_ok),
    .cache_rdata(cache_rdata), .busy(busy)
`ifdef DCACHE_ARB_PERF_EN
    , .perf_p0_grants(perf_p0_grants), .perf_p1_grants(perf_p1_grants),
    .perf_wait_cycles(perf_wait_cycles)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    checks++; if ({cache_ce, busy, p0_grant, p1_grant, p0_rvalid, p1_rvalid, cache_we} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000000", {cache_ce, busy, p0_grant, p1_grant, p0_rvalid, p1_rvalid, cache_we}); end
    checks++; if (cache_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", cache_addr); end
    checks++; if (cache_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", cache_data); end
    checks++; if (cache_sel !== 4'h0) begin errors++; $display("FAIL reset_sel got %h want 0", cache_sel); end
    checks++; if ({p0_rdata, p1_rdata} !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h/%h want 0/0", p0_rdata, p1_rdata); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_p0_load;
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h1000; p0_wdata = 32'h0; p0_sel = 4'hF;
    tick();
    checks++; if (p0_grant !== 1'b1) begin errors++; $display("FAIL load_grant got %b want 1", p0_grant); end
    p0_valid = 1'b0; p0_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({cache_ce, cache_we, cache_addr} !== {1'b1, 1'b0, 32'h1000}) begin
        errors++; $display("FAIL load_addr_hold[%0d] got ce=%b we=%b addr=%h want ce=1 we=0 addr=00001000", i, cache_ce, cache_we, cache_addr); end
      cache_addr_ok = (i == 2);
      tick();
    end
    cache_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({cache_ce, busy, p0_rvalid} !== 3'b010) begin
        errors++; $display("FAIL load_data_wait[%0d] got ce/busy/rv=%b want 010", i, {cache_ce, busy, p0_rvalid}); end
      cache_data_ok = (i == 2);
      cache_rdata   = (i == 2) ? 32'hDEAD_BEEF : 32'h0;
      tick();
    end
    cache_data_ok = 1'b0;
    checks++; if ({p0_rvalid, p1_rvalid, busy} !== 3'b100) begin
      errors++; $display("FAIL load_rvalid got rv0/rv1/busy=%b want 100", {p0_rvalid, p1_rvalid, busy}); end
    checks++; if (p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata got %h want deadbeef", p0_rdata); end
    tick();
    checks++; if (p0_rvalid !== 1'b0) begin errors++; $display("FAIL load_rvalid_pulse got %b want 0", p0_rvalid); end
    checks++; if (p0_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata_hold got %h want deadbeef", p0_rdata); end
  endtask

  task automatic test_starve;
    int got[$];
    int want[$];
    int cnt;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (cnt == LIM) begin want.push_back(1); cnt = 0; end
      else begin want.push_back(0); cnt++; end
    end
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h100; p0_sel = 4'hF;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h200; p1_sel = 4'hF;
    for (int cyc = 0; cyc < 100 && got.size() < 10; cyc++) begin
      tick();
      if (p0_grant) got.push_back(0);
      if (p1_grant) got.push_back(1);
      cache_addr_ok = cache_ce;
      cache_data_ok = cache_ce;
      cache_rdata   = $urandom;
    end
    p0_valid = 1'b0; p1_valid = 1'b0;
    tick();
    cache_addr_ok = 1'b0; cache_data_ok = 1'b0;
    tick();
    checks++; if (got.size() != 10) begin errors++; $display("FAIL starve_count got %0d grants want 10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      checks++; if (got[i] != want[i]) begin errors++; $display("FAIL starve_order[%0d] got p%0d want p%0d", i, got[i], want[i]); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL starve_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_store;
    p0_valid = 1'b1; p0_we = 1'b1; p0_addr = 32'h20; p0_sel = 4'h3; p0_wdata = 32'h1234;
    tick();
    checks++; if (p0_grant !== 1'b1) begin errors++; $display("FAIL store_grant got %b want 1", p0_grant); end
    p0_valid = 1'b0; p0_we = 1'b0; p0_addr = 32'h0; p0_sel = 4'hF; p0_wdata = 32'hFFFF;
    for (int i = 0; i < 3; i++) begin
      checks++; if ({cache_ce, cache_we, cache_sel, cache_addr, cache_data} !== {1'b1, 1'b1, 4'h3, 32'h20, 32'h1234}) begin
        errors++; $display("FAIL store_hold[%0d] got ce=%b we=%b sel=%h addr=%h data=%h want 1 1 3 00000020 00001234",
                           i, cache_ce, cache_we, cache_sel, cache_addr, cache_data); end
      cache_addr_ok = (i == 2);
      tick();
    end
    cache_addr_ok = 1'b0; cache_data_ok = 1'b1; cache_rdata = 32'hA5A5_5A5A;
    tick();
    cache_data_ok = 1'b0;
    checks++; if ({p0_rvalid, p0_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL store_resp got rv=%b rdata=%h want rv=1 rdata=0", p0_rvalid, p0_rdata); end
    tick();
  endtask

  task automatic test_flush_addr;
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h2000; p0_sel = 4'hF;
    p1_valid = 1'b1; p1_we = 1'b0; p1_addr = 32'h3000; p1_sel = 4'hF; p1_wdata = 32'h0;
    tick();
    checks++; if ({p0_grant, p1_grant} !== 2'b10) begin errors++; $display("FAIL fla_grant got %b want 10", {p0_grant, p1_grant}); end
    p0_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++; if ({cache_ce, busy, p0_rvalid} !== 3'b000) begin
      errors++; $display("FAIL fla_abort got ce/busy/rv=%b want 000", {cache_ce, busy, p0_rvalid}); end
    tick();
    checks++; if ({p1_grant, cache_ce, cache_addr, p0_rvalid} !== {1'b1, 1'b1, 32'h3000, 1'b0}) begin
      errors++; $display("FAIL fla_p1_next got g1=%b ce=%b addr=%h rv0=%b want 1 1 00003000 0", p1_grant, cache_ce, cache_addr, p0_rvalid); end
    p1_valid = 1'b0; cache_addr_ok = 1'b1; cache_data_ok = 1'b1; cache_rdata = 32'h77;
    tick();
    cache_addr_ok = 1'b0; cache_data_ok = 1'b0;
    checks++; if ({p1_rvalid, p0_rvalid, p1_rdata} !== {1'b1, 1'b0, 32'h77}) begin
      errors++; $display("FAIL fla_p1_resp got rv1=%b rv0=%b rdata=%h want 1 0 00000077", p1_rvalid, p0_rvalid, p1_rdata); end
    tick();
  endtask

  task automatic test_flush_data;
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h4000; p0_sel = 4'hF;
    tick();
    checks++; if (p0_grant !== 1'b1) begin errors++; $display("FAIL fld_grant got %b want 1", p0_grant); end
    p0_valid = 1'b0; cache_addr_ok = 1'b1;
    tick();
    cache_addr_ok = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({cache_ce, busy, p0_rvalid} !== 3'b010) begin
        errors++; $display("FAIL fld_drain[%0d] got ce/busy/rv=%b want 010", i, {cache_ce, busy, p0_rvalid}); end
      cache_data_ok = (i == 3);
      cache_rdata   = (i == 3) ? 32'h55 : 32'h0;
      tick();
    end
    cache_data_ok = 1'b0;
    checks++; if ({busy, p0_rvalid, p0_rdata} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL fld_end got busy=%b rv=%b rdata=%h want 0 0 0", busy, p0_rvalid, p0_rdata); end
    tick();
  endtask

  task automatic test_rst_mid;
    p0_valid = 1'b1; p0_we = 1'b0; p0_addr = 32'h5000; p0_sel = 4'hF;
    tick();
    p0_valid = 1'b0; cache_addr_ok = 1'b1;
    tick();
    cache_addr_ok = 1'b0;
    checks++; if ({busy, cache_ce, cache_addr} !== {1'b1, 1'b0, 32'h5000}) begin
      errors++; $display("FAIL rst_pre got busy=%b ce=%b addr=%h want 1 0 00005000", busy, cache_ce, cache_addr); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({busy, cache_ce, cache_we, p0_rvalid, p1_rvalid, p0_grant, p1_grant} !== 7'b0) begin
      errors++; $display("FAIL rst_async_ctrl got %b want 0000000", {busy, cache_ce, cache_we, p0_rvalid, p1_rvalid, p0_grant, p1_grant}); end
    checks++; if ({cache_addr, p1_rdata} !== 64'h0) begin
      errors++; $display("FAIL rst_async_data got addr=%h p1_rdata=%h want 0 0", cache_addr, p1_rdata); end
    tick();
    rst = 1'b1;
    tick();
    p1_valid = 1'b1; p1_we = 1'b1; p1_addr = 32'h6000; p1_wdata = 32'h99; p1_sel = 4'hF;
    tick();
    checks++; if ({p1_grant, cache_ce, cache_we, cache_addr, cache_data} !== {1'b1, 1'b1, 1'b1, 32'h6000, 32'h99}) begin
      errors++; $display("FAIL rst_p1_req got g1=%b ce=%b we=%b addr=%h data=%h want 1 1 1 00006000 00000099",
                         p1_grant, cache_ce, cache_we, cache_addr, cache_data); end
    p1_valid = 1'b0; cache_addr_ok = 1'b1;
    tick();
    cache_addr_ok = 1'b0; cache_data_ok = 1'b1; cache_rdata = 32'h1;
    tick();
    cache_data_ok = 1'b0;
    checks++; if ({p1_rvalid, p1_rdata} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL rst_p1_resp got rv=%b rdata=%h want 1 0", p1_rvalid, p1_rdata); end
    tick();
  endtask

  task automatic test_random;
    bit          pend[2];
    logic        rq_we[2];
    logic [31:0] rq_addr[2], rq_wd[2], m_rd[2];
    logic [3:0]  rq_sel[2];
    bit          m_busy, m_ce, m_acc, m_owner, m_we;
    logic [31:0] m_addr, m_wd;
    logic [3:0]  m_sel;
    int          m_starve;
    bit          e_g[2], e_rv[2], n_g[2], n_rv[2];
    bit          n_busy, n_ce, aok, dok, p0w, p1w;
    logic [31:0] rd;
    pend = '{0, 0}; m_rd = '{32'h0, 32'h0}; e_g = '{0, 0}; e_rv = '{0, 0};
    m_busy = 0; m_ce = 0; m_acc = 0; m_owner = 0; m_we = 0; m_addr = 0; m_wd = 0; m_sel = 0; m_starve = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      checks++; if ({p0_grant, p1_grant, p0_rvalid, p1_rvalid, busy, cache_ce} !== {e_g[0], e_g[1], e_rv[0], e_rv[1], m_busy, m_ce}) begin
        errors++; $display("FAIL rnd_ctrl cyc %0d got g0 g1 rv0 rv1 busy ce=%b want %b", cyc,
          {p0_grant, p1_grant, p0_rvalid, p1_rvalid, busy, cache_ce}, {e_g[0], e_g[1], e_rv[0], e_rv[1], m_busy, m_ce}); end
      checks++; if ({p0_rdata, p1_rdata} !== {m_rd[0], m_rd[1]}) begin
        errors++; $display("FAIL rnd_rdata cyc %0d got %h/%h want %h/%h", cyc, p0_rdata, p1_rdata, m_rd[0], m_rd[1]); end
      if (m_ce) begin
        checks++; if ({cache_we, cache_addr, cache_data, cache_sel} !== {m_we, m_addr, m_wd, m_sel}) begin
          errors++; $display("FAIL rnd_fields cyc %0d got we=%b addr=%h data=%h sel=%h want %b %h %h %h", cyc,
            cache_we, cache_addr, cache_data, cache_sel, m_we, m_addr, m_wd, m_sel); end
      end
      for (int p = 0; p < 2; p++) begin
        if (e_g[p]) pend[p] = 0;
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1; rq_we[p] = 1'($urandom_range(0, 1)); rq_addr[p] = $urandom;
          rq_wd[p] = $urandom; rq_sel[p] = 4'($urandom_range(0, 15));
        end
      end
      p0_valid = pend[0]; p0_we = rq_we[0]; p0_addr = rq_addr[0]; p0_wdata = rq_wd[0]; p0_sel = rq_sel[0];
      p1_valid = pend[1]; p1_we = rq_we[1]; p1_addr = rq_addr[1]; p1_wdata = rq_wd[1]; p1_sel = rq_sel[1];
      aok = m_ce && ($urandom_range(0, 2) == 0);
      dok = (m_acc || aok) && ($urandom_range(0, 1) == 0);
      rd  = $urandom;
      cache_addr_ok = aok; cache_data_ok = dok; cache_rdata = rd;
      n_g = '{0, 0}; n_rv = '{0, 0}; n_busy = m_busy; n_ce = m_ce;
      if (aok) begin n_ce = 0; m_acc = 1; end
      if (dok) begin
        n_busy = 0; m_acc = 0; n_rv[m_owner] = 1;
        m_rd[m_owner] = m_we ? 32'h0 : rd;
      end
      if (!m_busy) begin
        p1w = pend[1] && (m_starve == LIM || !pend[0]);
        p0w = pend[0] && !p1w;
        if (p1w || p0w) begin
          m_owner = p1w; m_we = rq_we[int'(p1w)]; m_addr = rq_addr[int'(p1w)];
          m_wd = rq_wd[int'(p1w)]; m_sel = rq_sel[int'(p1w)];
          n_g[int'(p1w)] = 1; n_busy = 1; n_ce = 1;
        end
        if (!pend[1] || p1w) m_starve = 0;
        else if (p0w && m_starve < LIM) m_starve++;
      end
      tick();
      e_g = n_g; e_rv = n_rv; m_busy = n_busy; m_ce = n_ce;
    end
    p0_valid = 1'b0; p1_valid = 1'b0; cache_addr_ok = 1'b0; cache_data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    p0_valid = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0; p0_sel = '0;
    p1_valid = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0; p1_sel = '0;
    cache_addr_ok = 1'b0; cache_data_ok = 1'b0; cache_rdata = '0;
    test_reset();
    test_p0_load();
    test_starve();
    test_store();
    test_flush_addr();
    test_flush_data();
    test_rst_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
